// File: rtl/switch_seq_pkg.sv
// switch_seq_pkg
//   Shared types and helpers for the two-source switch measurement scheduler:
//   FSM state encoding, data/counter widths and a saturating increment.
package switch_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ISSUE,
        ST_ACK
    } state_e;

    // Health counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/switch_seq_period_timer.sv
// period_timer
//   Free-running modulo-PERIOD counter. tick is high for the single cycle in
//   which the count equals PERIOD-1.
//   Ports:
//     clk   in  : rising-edge clock
//     rst_n in  : asynchronous active-low reset (count returns to 0)
//     tick  out : one cycle per period
module period_timer #(
    parameter int unsigned PERIOD = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_c;

    always_comb begin
        tick_c = (cnt_q == CW'(PERIOD - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_c;

endmodule

// File: rtl/switch_seq.sv
// switch_seq
//   Measurement scheduler for the two-source data switch. Every PERIOD cycles
//   it pulses start_m/start_f, captures the first result from each source,
//   presents the pair on datainm/datainf with a one-cycle over strobe and waits
//   up to ACK_MAX cycles for overout. With only one source answering before
//   TIMEOUT the surviving value is fed to both inputs and degraded is set.
//   Ports:
//     clk, rst_n             : clock, asynchronous active-low reset
//     en                     : permit new measurement cycles
//     start_m, start_f       : one-cycle source start pulses
//     done_m/data_m          : main result strobe and value
//     done_f/data_f          : fine result strobe and value
//     datainm, datainf       : switch inputs, held between issues
//     over, overout          : issue strobe and switch acknowledge
//     degraded               : last issue was single-source
//     miss_cnt, overrun_cnt,
//     ackerr_cnt             : saturating health counters
module switch_seq
    import switch_seq_pkg::*;
#(
    parameter int unsigned PERIOD  = 50000,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned ACK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              start_m,
    output logic              start_f,
    input  logic              done_m,
    input  logic              done_f,
    input  logic [DATA_W-1:0] data_m,
    input  logic [DATA_W-1:0] data_f,
    output logic [DATA_W-1:0] datainm,
    output logic [DATA_W-1:0] datainf,
    output logic              over,
    input  logic              overout,
    output logic              degraded,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  ackerr_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned AW = $clog2(ACK_MAX + 1);

    logic tick;

    period_timer #(
        .PERIOD(PERIOD)
    ) u_period_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    state_e            state_q, state_d;
    logic              got_m_q, got_m_d;
    logic              got_f_q, got_f_d;
    logic [DATA_W-1:0] lat_m_q, lat_m_d;
    logic [DATA_W-1:0] lat_f_q, lat_f_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [AW-1:0]     acnt_q, acnt_d;
    logic              ret_q, ret_d;
    logic              start_m_q, start_m_d;
    logic              start_f_q, start_f_d;
    logic              over_q, over_d;
    logic              degraded_q, degraded_d;
    logic [DATA_W-1:0] datainm_q, datainm_d;
    logic [DATA_W-1:0] datainf_q, datainf_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  overrun_cnt_q, overrun_cnt_d;
    logic [CNT_W-1:0]  ackerr_cnt_q, ackerr_cnt_d;

    // Flags/values including a strobe arriving this cycle, so a done on the
    // timeout cycle is honoured before the timeout decision.
    logic              got_m_now, got_f_now;
    logic [DATA_W-1:0] lat_m_now, lat_f_now;

    always_comb begin
        got_m_now = got_m_q | done_m;
        got_f_now = got_f_q | done_f;
        lat_m_now = (!got_m_q && done_m) ? data_m : lat_m_q;
        lat_f_now = (!got_f_q && done_f) ? data_f : lat_f_q;

        state_d       = state_q;
        got_m_d       = got_m_q;
        got_f_d       = got_f_q;
        lat_m_d       = lat_m_q;
        lat_f_d       = lat_f_q;
        tcnt_d        = tcnt_q;
        acnt_d        = acnt_q;
        start_m_d     = 1'b0;
        start_f_d     = 1'b0;
        over_d        = 1'b0;
        degraded_d    = degraded_q;
        datainm_d     = datainm_q;
        datainf_d     = datainf_q;
        miss_cnt_d    = miss_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        ackerr_cnt_d  = ackerr_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // ret_q marks the first IDLE cycle after a measurement; a tick
                // landing there still belongs to the busy period.
                if (tick) begin
                    if (ret_q) begin
                        overrun_cnt_d = sat_inc(overrun_cnt_q);
                    end else if (en) begin
                        state_d   = ST_START;
                        start_m_d = 1'b1;
                        start_f_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                got_m_d = 1'b0;
                got_f_d = 1'b0;
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                got_m_d = got_m_now;
                got_f_d = got_f_now;
                lat_m_d = lat_m_now;
                lat_f_d = lat_f_now;
                tcnt_d  = tcnt_q + TW'(1);
                if (got_m_now && got_f_now) begin
                    datainm_d  = lat_m_now;
                    datainf_d  = lat_f_now;
                    degraded_d = 1'b0;
                    over_d     = 1'b1;
                    state_d    = ST_ISSUE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    if (got_m_now) begin
                        datainm_d  = lat_m_now;
                        datainf_d  = lat_m_now;
                        degraded_d = 1'b1;
                        over_d     = 1'b1;
                        state_d    = ST_ISSUE;
                    end else if (got_f_now) begin
                        datainm_d  = lat_f_now;
                        datainf_d  = lat_f_now;
                        degraded_d = 1'b1;
                        over_d     = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                acnt_d  = '0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (overout) begin
                    state_d = ST_IDLE;
                end else if (acnt_q == AW'(ACK_MAX - 1)) begin
                    ackerr_cnt_d = sat_inc(ackerr_cnt_q);
                    state_d      = ST_IDLE;
                end else begin
                    acnt_d = acnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tick && (state_q != ST_IDLE)) begin
            overrun_cnt_d = sat_inc(overrun_cnt_q);
        end

        ret_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            got_m_q       <= 1'b0;
            got_f_q       <= 1'b0;
            lat_m_q       <= '0;
            lat_f_q       <= '0;
            tcnt_q        <= '0;
            acnt_q        <= '0;
            ret_q         <= 1'b0;
            start_m_q     <= 1'b0;
            start_f_q     <= 1'b0;
            over_q        <= 1'b0;
            degraded_q    <= 1'b0;
            datainm_q     <= '0;
            datainf_q     <= '0;
            miss_cnt_q    <= '0;
            overrun_cnt_q <= '0;
            ackerr_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            got_m_q       <= got_m_d;
            got_f_q       <= got_f_d;
            lat_m_q       <= lat_m_d;
            lat_f_q       <= lat_f_d;
            tcnt_q        <= tcnt_d;
            acnt_q        <= acnt_d;
            ret_q         <= ret_d;
            start_m_q     <= start_m_d;
            start_f_q     <= start_f_d;
            over_q        <= over_d;
            degraded_q    <= degraded_d;
            datainm_q     <= datainm_d;
            datainf_q     <= datainf_d;
            miss_cnt_q    <= miss_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            ackerr_cnt_q  <= ackerr_cnt_d;
        end
    end

    assign start_m     = start_m_q;
    assign start_f     = start_f_q;
    assign over        = over_q;
    assign degraded    = degraded_q;
    assign datainm     = datainm_q;
    assign datainf     = datainf_q;
    assign miss_cnt    = miss_cnt_q;
    assign overrun_cnt = overrun_cnt_q;
    assign ackerr_cnt  = ackerr_cnt_q;

endmodule

// File: tb/tb_switch_seq.sv
// tb_switch_seq
//   Directed bench for switch_seq. Instance u_dut uses PERIOD=100, TIMEOUT=20;
//   instance u_dut2 uses TIMEOUT=PERIOD-2 to exercise the tick that lands on
//   the return-to-IDLE cycle. Times below are relative to the START cycle S.
module tb_switch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        en2 = 1'b0;
    logic        done_m = 1'b0;
    logic        done_f = 1'b0;
    logic [31:0] data_m = '0;
    logic [31:0] data_f = '0;
    logic        overout = 1'b0;

    logic        start_m, start_f, over, degraded;
    logic [31:0] datainm, datainf;
    logic [15:0] miss_cnt, overrun_cnt, ackerr_cnt;

    logic        start_m2, start_f2, over2, degraded2;
    logic [31:0] datainm2, datainf2;
    logic [15:0] miss_cnt2, overrun_cnt2, ackerr_cnt2;

    int checks = 0;
    int failures = 0;
    int rel = 0;

    always #5 clk = ~clk;

    switch_seq #(.PERIOD(100), .TIMEOUT(20), .ACK_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .start_m(start_m), .start_f(start_f),
        .done_m(done_m), .done_f(done_f), .data_m(data_m), .data_f(data_f),
        .datainm(datainm), .datainf(datainf),
        .over(over), .overout(overout), .degraded(degraded),
        .miss_cnt(miss_cnt), .overrun_cnt(overrun_cnt), .ackerr_cnt(ackerr_cnt)
    );

    switch_seq #(.PERIOD(100), .TIMEOUT(98), .ACK_MAX(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2),
        .start_m(start_m2), .start_f(start_f2),
        .done_m(1'b0), .done_f(1'b0), .data_m(32'd0), .data_f(32'd0),
        .datainm(datainm2), .datainf(datainf2),
        .over(over2), .overout(1'b0), .degraded(degraded2),
        .miss_cnt(miss_cnt2), .overrun_cnt(overrun_cnt2), .ackerr_cnt(ackerr_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(input int t);
        while (rel < t) begin
            step();
            rel++;
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (start_m !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, {31'd0, start_m}, 32'd1);
        rel = 0;
    endtask

    initial begin
        logic seen;
        int   n;

        // Reset state
        step();
        chk("rst_start_m", {31'd0, start_m}, 32'd0);
        chk("rst_over", {31'd0, over}, 32'd0);
        chk("rst_datainm", datainm, 32'd0);
        chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        // 1: both sources answer
        wait_start("t1_start");
        chk("t1_start_f", {31'd0, start_f}, 32'd1);
        goto_rel(1);
        chk("t1_start_pulse", {31'd0, start_m}, 32'd0);
        goto_rel(3);
        done_m = 1'b1; data_m = 32'd1000;
        goto_rel(4);
        done_m = 1'b0;
        goto_rel(5);
        chk("t1_over_early", {31'd0, over}, 32'd0);
        done_f = 1'b1; data_f = 32'd1010;
        goto_rel(6);
        done_f = 1'b0;
        chk("t1_over", {31'd0, over}, 32'd1);
        chk("t1_datainm", datainm, 32'd1000);
        chk("t1_datainf", datainf, 32'd1010);
        chk("t1_degraded", {31'd0, degraded}, 32'd0);
        goto_rel(7);
        chk("t1_over_once", {31'd0, over}, 32'd0);
        overout = 1'b1;
        goto_rel(8);
        overout = 1'b0;
        goto_rel(12);
        chk("t1_ackerr", {16'd0, ackerr_cnt}, 32'd0);

        // 2: only fine source answers, with a repeat strobe that is ignored
        wait_start("t2_start");
        goto_rel(2);
        done_f = 1'b1; data_f = 32'd5000;
        goto_rel(3);
        done_f = 1'b0;
        goto_rel(4);
        done_f = 1'b1; data_f = 32'd7777;
        goto_rel(5);
        done_f = 1'b0;
        goto_rel(20);
        chk("t2_over_early", {31'd0, over}, 32'd0);
        goto_rel(21);
        chk("t2_over", {31'd0, over}, 32'd1);
        chk("t2_datainm", datainm, 32'd5000);
        chk("t2_datainf", datainf, 32'd5000);
        chk("t2_degraded", {31'd0, degraded}, 32'd1);
        goto_rel(22);
        chk("t2_over_once", {31'd0, over}, 32'd0);
        overout = 1'b1;
        goto_rel(23);
        overout = 1'b0;

        // 3: no source answers
        wait_start("t3_start");
        seen = 1'b0;
        while (rel < 21) begin
            step();
            rel++;
            if (over === 1'b1) seen = 1'b1;
            if (rel == 20) chk("t3_miss_early", {16'd0, miss_cnt}, 32'd0);
        end
        chk("t3_miss", {16'd0, miss_cnt}, 32'd1);
        chk("t3_no_over", {31'd0, seen}, 32'd0);
        chk("t3_datainm_held", datainm, 32'd5000);
        chk("t3_datainf_held", datainf, 32'd5000);
        chk("t3_degraded_sticky", {31'd0, degraded}, 32'd1);

        // 4: switch never acknowledges
        wait_start("t4_start");
        goto_rel(1);
        done_m = 1'b1; data_m = 32'd11;
        done_f = 1'b1; data_f = 32'd22;
        goto_rel(2);
        done_m = 1'b0; done_f = 1'b0;
        chk("t4_over", {31'd0, over}, 32'd1);
        chk("t4_datainm", datainm, 32'd11);
        chk("t4_datainf", datainf, 32'd22);
        goto_rel(6);
        chk("t4_ackerr_early", {16'd0, ackerr_cnt}, 32'd0);
        goto_rel(7);
        chk("t4_ackerr", {16'd0, ackerr_cnt}, 32'd1);

        // 5: main answers on the timeout cycle with fine already latched
        wait_start("t5_start");
        goto_rel(2);
        done_f = 1'b1; data_f = 32'd33;
        goto_rel(3);
        done_f = 1'b0;
        goto_rel(20);
        done_m = 1'b1; data_m = 32'd44;
        goto_rel(21);
        done_m = 1'b0;
        chk("t5_over", {31'd0, over}, 32'd1);
        chk("t5_datainm", datainm, 32'd44);
        chk("t5_datainf", datainf, 32'd33);
        chk("t5_degraded", {31'd0, degraded}, 32'd0);
        chk("t5_miss", {16'd0, miss_cnt}, 32'd1);
        goto_rel(22);
        overout = 1'b1;
        goto_rel(23);
        overout = 1'b0;
        chk("t5_overrun", {16'd0, overrun_cnt}, 32'd0);

        // 6: reset pulse during WAIT
        wait_start("t6_start");
        goto_rel(2);
        done_m = 1'b1; data_m = 32'd55;
        goto_rel(3);
        done_m = 1'b0;
        goto_rel(5);
        rst_n = 1'b0;
        #1;
        chk("t6_datainm", datainm, 32'd0);
        chk("t6_datainf", datainf, 32'd0);
        chk("t6_miss", {16'd0, miss_cnt}, 32'd0);
        chk("t6_ackerr", {16'd0, ackerr_cnt}, 32'd0);
        chk("t6_over", {31'd0, over}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (over === 1'b1 || start_m === 1'b1) seen = 1'b1;
        end
        chk("t6_quiet", {31'd0, seen}, 32'd0);

        // 7: TIMEOUT=PERIOD-2, tick on return-to-IDLE cycle is an overrun
        en  = 1'b0;
        en2 = 1'b1;
        n = 0;
        while (start_m2 !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("t7_start", {31'd0, start_m2}, 32'd1);
        for (int i = 1; i <= 99; i++) step();
        chk("t7_miss", {16'd0, miss_cnt2}, 32'd1);
        chk("t7_overrun_early", {16'd0, overrun_cnt2}, 32'd0);
        step();
        chk("t7_overrun", {16'd0, overrun_cnt2}, 32'd1);
        seen = 1'b0;
        if (start_m2 === 1'b1) seen = 1'b1;
        for (int i = 101; i <= 199; i++) begin
            step();
            if (start_m2 === 1'b1) seen = 1'b1;
        end
        chk("t7_skipped", {31'd0, seen}, 32'd0);
        step();
        chk("t7_next_start", {31'd0, start_m2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
